// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- UART receive control path.
//
// Oversamples an asynchronous serial line on div_clk (OVERSAMPLE x baud). It
// finds a start bit, confirms it at mid-bit and samples each data bit once per
// bit period. For each data bit it asks an external shift register to shift.
// When the stop bit has been sampled, it signals that the frame is complete.
//
// Ports
//   div_clk      sole clock, OVERSAMPLE x baud, rising edge
//   rst_n        asynchronous active-low reset
//   rx_serial    asynchronous serial input, idle high
//   rx_ack       consumer acknowledges the pending frame
//   shift_en     one-cycle pulse: shift in shift_bit
//   shift_bit    sampled data bit (holds last sample between pulses)
//   check_en     one-cycle pulse: frame complete, latch the byte
//   rx_valid     frame pending for the consumer
//   frame_error  last frame's stop bit sampled 0
//   overrun      sticky: a frame completed while the previous one was pending
//   busy         high in every state except IDLE
//   state_dbg    current FSM state encoding (IDLE=0 START=1 DATA=2 STOP=3 CHECK=4)
//
// Handshake: rx_valid rises the cycle after check_en and stays high until the
// consumer acknowledges. The consumer holds rx_ack high while rx_valid=1, and
// the acknowledgement is consumed on that rising edge. An rx_ack while
// rx_valid=0 has no effect. An rx_ack in the check_en cycle consumes the old
// frame. The new frame then stays pending, and overrun is not touched.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic       div_clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  input  logic       rx_ack,
  output logic       shift_en,
  output logic       shift_bit,
  output logic       check_en,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    CHECK = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              stop_q, stop_d;
  logic              armed_q, armed_d;
  logic              rx_meta, rx_s;
  logic              bit_hold_q;

  // Two-flop synchroniser. Both flops reset to the idle level so that the
  // reset release cannot look like a start bit.
  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    armed_d  = armed_q;
    shift_en = 1'b0;
    check_en = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        // After a framing error the line may be stuck low (break). Wait for
        // a high level before accepting another falling edge.
        if (!armed_q) begin
          if (rx_s) armed_d = 1'b1;
        end else if (!rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (tick_q == TICK_MID) begin
          tick_d = '0;
          bit_d  = '0;
          // A start bit that is high again at mid-bit is only a glitch.
          state_d = rx_s ? IDLE : DATA;
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      DATA: begin
        if (tick_q == TICK_LAST) begin
          shift_en = 1'b1;
          tick_d   = '0;
          bit_d    = bit_q + BIT_ONE;
          if (bit_q == BIT_LAST) state_d = STOP;
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      STOP: begin
        if (tick_q == TICK_LAST) begin
          stop_d  = rx_s;
          tick_d  = '0;
          state_d = CHECK;
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      CHECK: begin
        check_en = 1'b1;
        armed_d  = stop_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // shift_bit is the live sample during the pulse. Between pulses it holds
  // the value last sampled.
  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_hold_q <= 1'b0;
    end else if (shift_en) begin
      bit_hold_q <= rx_s;
    end
  end

  assign shift_bit = shift_en ? rx_s : bit_hold_q;

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else if (check_en) begin
      frame_error <= ~stop_q;
      rx_valid    <= 1'b1;
      if (rx_valid && !rx_ack) overrun <= 1'b1;
    end else if (rx_ack && rx_valid) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  localparam int FRAME_LAT = 152;  // 16/2 + (8+1)*16 cycles

  logic       div_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_ack = 1'b0;
  logic       shift_en, shift_bit, check_en, rx_valid, frame_error, overrun, busy;
  logic [2:0] state_dbg;

  uart_rx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .div_clk     (div_clk),
    .rst_n       (rst_n),
    .rx_serial   (rx_serial),
    .rx_ack      (rx_ack),
    .shift_en    (shift_en),
    .shift_bit   (shift_bit),
    .check_en    (check_en),
    .rx_valid    (rx_valid),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 div_clk = ~div_clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [0:0]  exp_bit_q[$];
  logic [10:0] exp_q[$];  // {data[7:0], frame_error, rx_valid, overrun}

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         start_cyc = 0;
  int         nshift = 0;
  int         shift_total = 0;
  int         check_total = 0;
  logic       prev_busy = 1'b0;
  logic       pend = 1'b0;
  logic [2:0] pend_flags = '0;
  logic [7:0] acc = '0;
  logic [0:0] eb;
  logic [10:0] ef;

  always @(negedge div_clk) begin
    cyc++;
    if (!rst_n) begin
      acc = '0;
      nshift = 0;
      pend = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        checks++;
        if ({frame_error, rx_valid, overrun} !== pend_flags) begin
          failures++;
          $display("FAIL status got fe/valid/ovr=%b exp=%b", {frame_error, rx_valid, overrun}, pend_flags);
        end
      end
      if (busy && !prev_busy) start_cyc = cyc;
      prev_busy = busy;
      if (shift_en) begin
        shift_total++;
        checks++;
        if (exp_bit_q.size() == 0) begin
          failures++;
          $display("FAIL shift_unexpected got bit=%b exp=no pulse", shift_bit);
        end else begin
          eb = exp_bit_q.pop_front();
          if (shift_bit !== eb[0] || check_en !== 1'b0) begin
            failures++;
            $display("FAIL shift_bit got bit=%b check_en=%b exp bit=%b check_en=0", shift_bit, check_en, eb[0]);
          end
        end
        if (nshift < 8) acc[nshift] = shift_bit;
        nshift++;
      end
      if (check_en) begin
        check_total++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL check_unexpected got check_en=1 exp=no frame");
        end else begin
          ef = exp_q.pop_front();
          if (acc !== ef[10:3] || nshift != 8 || (cyc - start_cyc) != FRAME_LAT) begin
            failures++;
            $display("FAIL frame got data=%h shifts=%0d lat=%0d exp data=%h shifts=8 lat=%0d",
                     acc, nshift, cyc - start_cyc, ef[10:3], FRAME_LAT);
          end
          pend = 1'b1;
          pend_flags = ef[2:0];
        end
        nshift = 0;
        acc = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge div_clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_serial = b;
    tick(16);
  endtask

  // Idle high for 4 cycles, then a start bit, 8 data bits LSB first, and the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic [2:0] flags);
    for (int i = 0; i < 8; i++) exp_bit_q.push_back(d[i]);
    exp_q.push_back({d, flags});
    rx_serial = 1'b1;
    tick(4);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_b);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    check("ack_clears", {30'd0, rx_valid, overrun}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int bc;
  int s0;
  int c0;
  int w;

  initial begin
    rst_n = 1'b0;
    rx_serial = 1'b1;
    tick(3);
    check("reset_outputs", {22'd0, shift_en, shift_bit, check_en, rx_valid, frame_error,
                            overrun, busy, state_dbg}, 32'd0);
    rst_n = 1'b1;
    tick(3);
    check("idle_after_reset", {31'd0, busy}, 32'd0);

    // Frame 0xA5 with a good stop bit.
    send_frame(8'hA5, 1'b1, 3'b010);
    tick(2);
    do_ack();

    // A low glitch of 4 cycles on the idle line.
    s0 = shift_total;
    c0 = check_total;
    bc = 0;
    rx_serial = 1'b0;
    repeat (4) begin tick(1); if (busy) bc++; end
    rx_serial = 1'b1;
    repeat (26) begin tick(1); if (busy) bc++; end
    check("glitch_busy_cycles", bc, 32'd8);
    check("glitch_no_pulses", (shift_total - s0) + (check_total - c0), 32'd0);
    check("glitch_idle", {29'd0, state_dbg}, 32'd0);

    // Frame 0x3C with a bad stop bit, then the line held low: no new start.
    send_frame(8'h3C, 1'b0, 3'b110);
    rx_serial = 1'b0;
    bc = 0;
    repeat (40) begin tick(1); if (busy) bc++; end
    check("break_no_start", bc, 32'd0);
    do_ack();
    check("frame_error_holds", {31'd0, frame_error}, 32'd1);
    send_frame(8'h55, 1'b1, 3'b010);
    tick(2);
    do_ack();

    // Two back-to-back frames with no ack.
    send_frame(8'h12, 1'b1, 3'b010);
    send_frame(8'h34, 1'b1, 3'b011);
    tick(2);
    do_ack();

    // An ack in the same cycle as check_en consumes the older pending frame.
    send_frame(8'h6B, 1'b1, 3'b010);
    fork
      send_frame(8'hC9, 1'b1, 3'b010);
      begin
        w = 0;
        while (!check_en && w < 400) begin tick(1); w++; end
        if (!check_en) begin
          checks++;
          failures++;
          $display("FAIL ack_align got check_en timeout exp check_en within 400 cycles");
        end else begin
          rx_ack = 1'b1;
          tick(1);
          rx_ack = 1'b0;
        end
      end
    join
    tick(2);
    do_ack();

    // A pending error frame, then reset after the 4th shift of a new frame.
    send_frame(8'hE7, 1'b0, 3'b110);
    s0 = shift_total;
    c0 = check_total;
    for (int i = 0; i < 4; i++) exp_bit_q.push_back(i == 0 ? 1'b1 : 1'b0);
    rx_serial = 1'b1;
    tick(4);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    check("abort_shift_count", shift_total - s0, 32'd4);
    rx_serial = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {22'd0, shift_en, shift_bit, check_en, rx_valid, frame_error,
                            overrun, busy, state_dbg}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(10);
    check("abort_no_check", (check_total - c0) + {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b1, 3'b010);
    tick(2);
    do_ack();

    tick(5);
    check("bits_drained", exp_bit_q.size(), 32'd0);
    check("frames_drained", exp_q.size(), 32'd0);
    check("frame_count", check_total, 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
